// File: rtl/div_pkg.sv
// Shared definitions for the 8-by-4 sequential restoring divider:
// FSM encoding and the fixed iteration / divide-by-zero constants.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          ITER_CNT     = 8;
  localparam logic [7:0]  DBZ_QUOTIENT = 8'hFF;

endpackage

// File: rtl/cla_adder4.sv
// 4-bit carry-lookahead adder: sum = a + b + cin, with carry out.
module cla_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor through the CLA, keep the difference on success or restore.
module div_step (
  input  logic [4:0] partial,
  input  logic       din,
  input  logic [3:0] divisor,
  output logic       ok,
  output logic [4:0] next_partial
);

  logic [4:0] shifted;
  logic [3:0] diff;
  logic       carry;

  // Between steps the partial remainder is below the divisor, so bit 4 is 0.
  logic unused_partial_msb;
  assign unused_partial_msb = partial[4];

  assign shifted = {partial[3:0], din};

  // a + ~d + 1 = a - d; carry out means shifted[3:0] >= divisor.
  cla_adder4 u_cla (
    .a    (shifted[3:0]),
    .b    (~divisor),
    .cin  (1'b1),
    .sum  (diff),
    .cout (carry)
  );

  // With shifted[4] set the true value is 16 + shifted[3:0], always >= divisor,
  // and the low nibble of the CLA result is still the exact difference.
  assign ok           = shifted[4] | carry;
  assign next_partial = ok ? {1'b0, diff} : shifted;

endmodule

// File: rtl/seq_divider_8by4.sv
// 8-bit by 4-bit sequential restoring divider: one quotient bit per clock,
// results and done pulse registered; divide-by-zero short-cuts to DONE.
module seq_divider_8by4
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  // Handshake: start is a request honoured only while IDLE (operands sampled
  // on that edge); done is a one-cycle pulse marking quotient/remainder/
  // div_by_zero valid, which then hold until the next completion.

  state_t     state;
  state_t     state_next;
  logic [2:0] cnt;
  logic [4:0] partial;
  logic [7:0] work;      // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [3:0] dsr;
  logic       step_ok;
  logic [4:0] step_partial;
  logic       last_step;

  assign last_step = (cnt == 3'(ITER_CNT - 1));

  div_step u_step (
    .partial      (partial),
    .din          (work[7]),
    .divisor      (dsr),
    .ok           (step_ok),
    .next_partial (step_partial)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (divisor == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are decoded from the next state so they are flops aligned with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= 3'd0;
      partial     <= 5'd0;
      work        <= 8'd0;
      dsr         <= 4'd0;
      quotient    <= 8'd0;
      remainder   <= 4'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != 4'd0) begin
              work        <= dividend;
              dsr         <= divisor;
              partial     <= 5'd0;
              cnt         <= 3'd0;
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= DBZ_QUOTIENT;
              remainder   <= dividend[3:0];
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          partial <= step_partial;
          work    <= {work[6:0], step_ok};
          cnt     <= cnt + 3'd1;
          if (last_step) begin
            quotient  <= {work[6:0], step_ok};
            remainder <= step_partial[3:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Directed bench for seq_divider_8by4 plus an exhaustive sweep against the
// integer / and % operators.
module tb_seq_divider_8by4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider_8by4 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Driver: called just after a rising edge with the DUT in IDLE. lat counts
  // edges from the one that samples start up to the one that raises done.
  // Returns one edge after done, with the DUT back in IDLE.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        output int lat, output logic [7:0] q, output logic [3:0] r,
                        output logic z, output logic saw_busy, output logic done_after);
    saw_busy = 1'b0;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (busy) saw_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) saw_busy = 1'b1;
    q = quotient; r = remainder; z = div_by_zero;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    int lat; logic [7:0] q; logic [3:0] r; logic z, sb, da;
    #3 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (quotient !== 8'd0) $display("FAIL reset_quotient: got %h want 00", quotient); else n_pass++;
    n_checks++; if (remainder !== 4'd0) $display("FAIL reset_remainder: got %h want 0", remainder); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b want 0", div_by_zero); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    do_div(8'd9, 4'd2, lat, q, r, z, sb, da);
    n_checks++; if (lat != 9) $display("FAIL first_start_latency: got %0d want 9", lat); else n_pass++;
    n_checks++; if (q !== 8'd4) $display("FAIL first_9_2_q: got %0d want 4", q); else n_pass++;
    n_checks++; if (r !== 4'd1) $display("FAIL first_9_2_r: got %0d want 1", r); else n_pass++;
  endtask

  task automatic test_100_by_7();
    int lat; logic [7:0] q; logic [3:0] r; logic z, sb, da;
    do_div(8'd100, 4'd7, lat, q, r, z, sb, da);
    n_checks++; if (q !== 8'd14) $display("FAIL d100_7_q: got %0d want 14", q); else n_pass++;
    n_checks++; if (r !== 4'd2) $display("FAIL d100_7_r: got %0d want 2", r); else n_pass++;
    n_checks++; if (z !== 1'b0) $display("FAIL d100_7_dbz: got %b want 0", z); else n_pass++;
    n_checks++; if (lat != 9) $display("FAIL d100_7_latency: got %0d want 9", lat); else n_pass++;
    n_checks++; if (sb !== 1'b1) $display("FAIL d100_7_busy_seen: got %b want 1", sb); else n_pass++;
    n_checks++; if (da !== 1'b0) $display("FAIL d100_7_done_one_cycle: got %b want 0", da); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (quotient !== 8'd14) $display("FAIL d100_7_hold_q: got %0d want 14", quotient); else n_pass++;
    n_checks++; if (remainder !== 4'd2) $display("FAIL d100_7_hold_r: got %0d want 2", remainder); else n_pass++;
  endtask

  task automatic test_extremes();
    int lat; logic [7:0] q; logic [3:0] r; logic z, sb, da;
    do_div(8'd255, 4'd15, lat, q, r, z, sb, da);
    n_checks++; if (q !== 8'd17) $display("FAIL d255_15_q: got %0d want 17", q); else n_pass++;
    n_checks++; if (r !== 4'd0) $display("FAIL d255_15_r: got %0d want 0", r); else n_pass++;
    do_div(8'd255, 4'd1, lat, q, r, z, sb, da);
    n_checks++; if (q !== 8'd255) $display("FAIL d255_1_q: got %0d want 255", q); else n_pass++;
    n_checks++; if (r !== 4'd0) $display("FAIL d255_1_r: got %0d want 0", r); else n_pass++;
  endtask

  task automatic test_small();
    int lat; logic [7:0] q; logic [3:0] r; logic z, sb, da;
    do_div(8'd5, 4'd9, lat, q, r, z, sb, da);
    n_checks++; if (q !== 8'd0) $display("FAIL d5_9_q: got %0d want 0", q); else n_pass++;
    n_checks++; if (r !== 4'd5) $display("FAIL d5_9_r: got %0d want 5", r); else n_pass++;
    do_div(8'd0, 4'd3, lat, q, r, z, sb, da);
    n_checks++; if (q !== 8'd0) $display("FAIL d0_3_q: got %0d want 0", q); else n_pass++;
    n_checks++; if (r !== 4'd0) $display("FAIL d0_3_r: got %0d want 0", r); else n_pass++;
  endtask

  task automatic test_div_by_zero();
    int lat; logic [7:0] q; logic [3:0] r; logic z, sb, da;
    do_div(8'd200, 4'd0, lat, q, r, z, sb, da);
    n_checks++; if (z !== 1'b1) $display("FAIL dbz_flag: got %b want 1", z); else n_pass++;
    n_checks++; if (q !== 8'hFF) $display("FAIL dbz_q: got %h want ff", q); else n_pass++;
    n_checks++; if (r !== 4'd8) $display("FAIL dbz_r: got %0d want 8", r); else n_pass++;
    n_checks++; if (lat != 1) $display("FAIL dbz_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (sb !== 1'b0) $display("FAIL dbz_busy_seen: got %b want 0", sb); else n_pass++;
    n_checks++; if (da !== 1'b0) $display("FAIL dbz_done_one_cycle: got %b want 0", da); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (div_by_zero !== 1'b1) $display("FAIL dbz_hold: got %b want 1", div_by_zero); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ndone;
    logic [7:0] q; logic [3:0] r;
    ndone = 0; q = 8'd0; r = 4'd0;
    start = 1'b1; dividend = 8'd100; divisor = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    start = 1'b1; dividend = 8'd50; divisor = 4'd4;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'd0; divisor = 4'd0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++; q = quotient; r = remainder;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (ndone != 1) $display("FAIL b2b_done_count: got %0d want 1", ndone); else n_pass++;
    n_checks++; if (q !== 8'd14) $display("FAIL b2b_q: got %0d want 14", q); else n_pass++;
    n_checks++; if (r !== 4'd2) $display("FAIL b2b_r: got %0d want 2", r); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL b2b_dbz_cleared: got %b want 0", div_by_zero); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle_after: got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat, ndone; logic [7:0] q; logic [3:0] r; logic z, sb, da;
    ndone = 0;
    start = 1'b1; dividend = 8'd100; divisor = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else n_pass++;
    n_checks++; if (quotient !== 8'd0) $display("FAIL midrst_q: got %0d want 0", quotient); else n_pass++;
    n_checks++; if (remainder !== 4'd0) $display("FAIL midrst_r: got %0d want 0", remainder); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL midrst_dbz: got %b want 0", div_by_zero); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) ndone++;
      @(posedge clk); #1;
    end
    n_checks++; if (ndone != 0) $display("FAIL midrst_no_resume: got %0d active cycles want 0", ndone); else n_pass++;
    do_div(8'd9, 4'd2, lat, q, r, z, sb, da);
    n_checks++; if (q !== 8'd4) $display("FAIL midrst_9_2_q: got %0d want 4", q); else n_pass++;
    n_checks++; if (r !== 4'd1) $display("FAIL midrst_9_2_r: got %0d want 1", r); else n_pass++;
  endtask

  task automatic test_sweep();
    int lat; logic [7:0] q; logic [3:0] r; logic z, sb, da;
    int exp_q, exp_r;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div(8'(a), 4'(b), lat, q, r, z, sb, da);
        exp_q = a / b;
        exp_r = a % b;
        n_checks++;
        if (q !== 8'(exp_q) || r !== 4'(exp_r) || lat != 9)
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=9",
                   a, b, q, r, lat, exp_q, exp_r);
        else n_pass++;
        n_checks++;
        if ((int'(q) * b + int'(r) != a) || (int'(r) >= b))
          $display("FAIL identity %0d/%0d: got q=%0d r=%0d want q*d+r=%0d with r<d", a, b, q, r, a);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_100_by_7();
    test_extremes();
    test_small();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
